json_feedback_parser: RTL and testbench

//  Receive-side counterpart of the JSON motor-command stream: consumes bytes from the UART RX
//  (one byte per rx_valid strobe), parses frames of the form {"T":n,"L":-x.xx,"R":-x.xx}\n and

---
 rtl/json_parser_pkg.sv | 54 +++++
 rtl/json_value_acc.sv | 48 ++++
 rtl/json_feedback_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_json_feedback_parser.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/json_parser_pkg.sv
// Shared types and constants for the JSON feedback-frame parser.
package json_parser_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned VAL_W       = 16;
  localparam int unsigned ACC_W       = 15;
  localparam int unsigned NXT_W       = ACC_W + 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned T_DIGITS    = 3;
  localparam int unsigned T_MAX_VAL   = 255;
  localparam int unsigned FRAC_DIGITS = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEY_OQ,
    S_KEY,
    S_KEY_CQ,
    S_COLON,
    S_VAL_START,
    S_INT,
    S_FRAC,
    S_SEP,
    S_EOL
  } parser_state_e;

  localparam logic [BYTE_W-1:0] LBRACE = 8'h7B;
  localparam logic [BYTE_W-1:0] RBRACE = 8'h7D;
  localparam logic [BYTE_W-1:0] QUOTE  = 8'h22;
  localparam logic [BYTE_W-1:0] COLON  = 8'h3A;
  localparam logic [BYTE_W-1:0] COMMA  = 8'h2C;
  localparam logic [BYTE_W-1:0] MINUS  = 8'h2D;
  localparam logic [BYTE_W-1:0] DOT    = 8'h2E;
  localparam logic [BYTE_W-1:0] LF     = 8'h0A;
  localparam logic [BYTE_W-1:0] KEY_T  = 8'h54;
  localparam logic [BYTE_W-1:0] KEY_L  = 8'h4C;
  localparam logic [BYTE_W-1:0] KEY_R  = 8'h52;
  localparam logic [BYTE_W-1:0] ASC_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASC_9  = 8'h39;

  typedef logic [1:0] field_t;
  localparam field_t FIELD_T = 2'd0;
  localparam field_t FIELD_L = 2'd1;
  localparam field_t FIELD_R = 2'd2;

  // Key character expected for the field currently being parsed.
  function automatic logic [BYTE_W-1:0] key_char(input field_t f);
    logic [BYTE_W-1:0] c;
    c = KEY_R;
    if (f == FIELD_T) c = KEY_T;
    else if (f == FIELD_L) c = KEY_L;
    return c;
  endfunction

endpackage

// File: rtl/json_value_acc.sv
// Decimal value accumulator: acc*10+d, sign latch, digit count, overflow detect.
module json_value_acc
  import json_parser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_cnt_clear,
  input  logic             i_digit_en,
  input  logic [3:0]       i_digit,
  input  logic             i_neg_set,
  output logic             o_neg,
  output logic [CNT_W-1:0] o_cnt,
  output logic [NXT_W-1:0] o_next_c,
  output logic             o_ovf_c,
  output logic [VAL_W-1:0] o_value_c
);

  logic [ACC_W-1:0] r_acc;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  assign o_next_c  = NXT_W'(r_acc) * NXT_W'(10) + NXT_W'(i_digit);
  assign o_ovf_c   = |o_next_c[NXT_W-1:ACC_W];
  assign o_value_c = r_neg ? (VAL_W'(0) - VAL_W'(r_acc)) : VAL_W'(r_acc);
  assign o_neg     = r_neg;
  assign o_cnt     = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_cnt_clear) r_cnt <= '0;
      if (i_digit_en) begin
        r_acc <= ACC_W'(o_next_c);
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_neg_set) r_neg <= 1'b1;
    end
  end

endmodule

// File: rtl/json_feedback_parser.sv
// Parses {"T":n,"L":-x.xx,"R":-x.xx}\n frames from a UART byte stream.
// Define JSON_PARSER_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES clocks.
module json_feedback_parser
  import json_parser_pkg::*;
#(
  parameter int unsigned INT_DIGITS     = 2
`ifdef JSON_PARSER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [7:0]        frame_type,
  output logic [VAL_W-1:0]  left_val,
  output logic [VAL_W-1:0]  right_val,
  output logic              frame_valid,
  output logic              frame_error
);

  localparam logic [CNT_W-1:0] INT_MAX  = CNT_W'(INT_DIGITS);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(T_DIGITS);
  localparam logic [CNT_W-1:0] FRAC_END = CNT_W'(FRAC_DIGITS - 1);

  parser_state_e    r_state, w_state_nxt;
  field_t           r_field, w_field_nxt;
  logic [7:0]       r_t_pend, r_type;
  logic [VAL_W-1:0] r_l_pend, r_r_pend, r_left, r_right;
  logic             r_valid, r_error;

  logic             w_err, w_done, w_timeout;
  logic             w_acc_clr, w_cnt_clr, w_dig_en, w_neg_set;
  logic             w_lat_t, w_lat_l, w_lat_r;
  logic             w_is_digit, w_int_ok, w_neg, w_ovf;
  logic [3:0]       w_digit;
  logic [CNT_W-1:0] w_cnt;
  logic [NXT_W-1:0] w_next;
  logic [VAL_W-1:0] w_value;

  assign w_is_digit = (rx_data >= ASC_0) && (rx_data <= ASC_9);
  assign w_digit    = 4'(rx_data - ASC_0);
  assign w_int_ok   = (r_field == FIELD_T) ?
                      ((w_cnt < T_MAX) && (w_next <= NXT_W'(T_MAX_VAL))) :
                      ((w_cnt < INT_MAX) && !w_ovf);

  json_value_acc u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_acc_clr),
    .i_cnt_clear(w_cnt_clr),
    .i_digit_en (w_dig_en),
    .i_digit    (w_digit),
    .i_neg_set  (w_neg_set),
    .o_neg      (w_neg),
    .o_cnt      (w_cnt),
    .o_next_c   (w_next),
    .o_ovf_c    (w_ovf),
    .o_value_c  (w_value)
  );

`ifdef JSON_PARSER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // A byte arriving on the expiry cycle keeps the frame alive.
  assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                     (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_to_cnt <= '0;
    else if (rx_valid || (r_state == S_IDLE) || w_timeout) r_to_cnt <= '0;
    else r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state, field sequencing and accumulator control.
  always_comb begin
    w_state_nxt = r_state;
    w_field_nxt = r_field;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_acc_clr   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_dig_en    = 1'b0;
    w_neg_set   = 1'b0;
    w_lat_t     = 1'b0;
    w_lat_l     = 1'b0;
    w_lat_r     = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == LBRACE) begin
            w_state_nxt = S_KEY_OQ;
            w_field_nxt = FIELD_T;
            w_acc_clr   = 1'b1;
          end
        end
        S_KEY_OQ: begin
          if (rx_data == QUOTE) w_state_nxt = S_KEY;
          else w_err = 1'b1;
        end
        S_KEY: begin
          if (rx_data == key_char(r_field)) w_state_nxt = S_KEY_CQ;
          else w_err = 1'b1;
        end
        S_KEY_CQ: begin
          if (rx_data == QUOTE) w_state_nxt = S_COLON;
          else w_err = 1'b1;
        end
        S_COLON: begin
          if (rx_data == COLON) begin
            w_state_nxt = S_VAL_START;
            w_acc_clr   = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        S_VAL_START: begin
          if (w_is_digit) begin
            w_dig_en    = 1'b1;
            w_state_nxt = S_INT;
          end else if ((rx_data == MINUS) && (r_field != FIELD_T) && !w_neg) begin
            w_neg_set = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        S_INT: begin
          if (w_is_digit && w_int_ok) begin
            w_dig_en = 1'b1;
          end else if ((rx_data == DOT) && (r_field != FIELD_T)) begin
            w_state_nxt = S_FRAC;
            w_cnt_clr   = 1'b1;
          end else if ((rx_data == COMMA) && (r_field == FIELD_T)) begin
            w_lat_t     = 1'b1;
            w_field_nxt = FIELD_L;
            w_state_nxt = S_KEY_OQ;
          end else begin
            w_err = 1'b1;
          end
        end
        S_FRAC: begin
          if (w_is_digit && !w_ovf) begin
            w_dig_en = 1'b1;
            if (w_cnt == FRAC_END) w_state_nxt = S_SEP;
          end else begin
            w_err = 1'b1;
          end
        end
        S_SEP: begin
          if ((rx_data == COMMA) && (r_field == FIELD_L)) begin
            w_lat_l     = 1'b1;
            w_field_nxt = FIELD_R;
            w_state_nxt = S_KEY_OQ;
          end else if ((rx_data == RBRACE) && (r_field == FIELD_R)) begin
            w_lat_r     = 1'b1;
            w_state_nxt = S_EOL;
          end else begin
            w_err = 1'b1;
          end
        end
        S_EOL: begin
          if (rx_data == LF) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // A stray '{' mid-frame is taken as the start of a fresh frame.
      if (w_err) begin
        w_state_nxt = (rx_data == LBRACE) ? S_KEY_OQ : S_IDLE;
        w_field_nxt = FIELD_T;
        w_acc_clr   = 1'b1;
      end
    end else if (w_timeout) begin
      w_err       = 1'b1;
      w_state_nxt = S_IDLE;
      w_field_nxt = FIELD_T;
      w_acc_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_field  <= FIELD_T;
      r_t_pend <= '0;
      r_l_pend <= '0;
      r_r_pend <= '0;
      r_type   <= '0;
      r_left   <= '0;
      r_right  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_field <= w_field_nxt;
      r_valid <= w_done;
      r_error <= w_err;
      if (w_lat_t) r_t_pend <= 8'(w_value);
      if (w_lat_l) r_l_pend <= w_value;
      if (w_lat_r) r_r_pend <= w_value;
      // Fields are published together only once the terminating LF arrives.
      if (w_done) begin
        r_type  <= r_t_pend;
        r_left  <= r_l_pend;
        r_right <= r_r_pend;
      end
    end
  end

  assign frame_type  = r_type;
  assign left_val    = r_left;
  assign right_val   = r_right;
  assign frame_valid = r_valid;
  assign frame_error = r_error;

endmodule

// File: tb/tb_json_feedback_parser.sv
// Self-checking bench for json_feedback_parser: directed grammar cases plus random frames.
module tb_json_feedback_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  frame_type;
  logic [15:0] left_val, right_val;
  logic        frame_valid, frame_error;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  ref_t = '0;
  logic [15:0] ref_l = '0;
  logic [15:0] ref_r = '0;

  localparam int NBAD = 17;
  string bad_s [NBAD] = '{
    "{\"T\":1,\"X\"",
    "{\"T\":300",
    "{\"T\":1,\"L\":-123.00",
    "{\"T\":256",
    "{\"T\":0001",
    "{\"L\"",
    "{\"T\":-",
    "{\"T\":1.",
    "{\"T\":1,\"L\":0.5,",
    "{\"T\":1,\"L\":0.500",
    "{\"T\":1,\"L\":1.00}",
    "{\"T\":1,\"L\":--1",
    "{\"T\":1,\"L\":1.00,\"R\":1.00,",
    "{\"T\":1,\"L\":1.00,\"R\":1.00}}",
    "{\"T\"1",
    "{\"T\":1,\"L\":.50",
    "{\"T\":1,\"L\":1.00,\"R\":1.00}x"
  };
  int bad_i [NBAD] = '{8, 7, 14, 7, 8, 2, 5, 6, 14, 15, 15, 12, 24, 25, 4, 11, 25};

  json_feedback_parser #(.INT_DIGITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_type (frame_type),
    .left_val   (left_val),
    .right_val  (right_val),
    .frame_valid(frame_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, " frame_type"}, 32'(frame_type), 32'(ref_t));
    check({tag, " left_val"},   32'(left_val),   32'(ref_l));
    check({tag, " right_val"},  32'(right_val),  32'(ref_r));
  endtask

  // Streams s; expects an error pulse after byte err_idx and, if ok, a valid pulse after the last byte.
  task automatic send(input string s, input int err_idx, input bit ok,
                      input logic [7:0] t, input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 'x;
      check("frame_error", 32'(frame_error), 32'(i == err_idx));
      check("frame_valid", 32'(frame_valid), 32'(ok && (i == s.len() - 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    if (ok) begin
      ref_t = t;
      ref_l = l;
      ref_r = r;
    end
    check_fields("fields");
  endtask

  task automatic gen_lr(output string s, output logic [15:0] v);
    int ip, fp, mag;
    bit neg;
    neg = ($urandom_range(0, 1) == 1);
    ip  = int'($urandom_range(0, 99));
    fp  = int'($urandom_range(0, 99));
    s   = $sformatf("%0d.%02d", ip, fp);
    if (ip < 10 && $urandom_range(0, 1) == 1) s = {"0", s};
    if (neg) s = {"-", s};
    mag = ip * 100 + fp;
    v   = neg ? 16'(-mag) : 16'(mag);
  endtask

  task automatic gen_frame(output string s, output logic [7:0] t,
                           output logic [15:0] l, output logic [15:0] r);
    string ts, ls, rs;
    int tv;
    tv = int'($urandom_range(0, 255));
    ts = $sformatf("%0d", tv);
    if (tv < 10 && $urandom_range(0, 1) == 1) ts = {"0", ts};
    t = 8'(tv);
    gen_lr(ls, l);
    gen_lr(rs, r);
    s = {"{\"T\":", ts, ",\"L\":", ls, ",\"R\":", rs, "}\n"};
  endtask

  initial begin
    string s, s2;
    logic [7:0] t;
    logic [15:0] l, r;
    int idx;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset frame_valid", 32'(frame_valid), 32'(0));
    check("reset frame_error", 32'(frame_error), 32'(0));
    check_fields("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send("{\"T\":1,\"L\":-0.50,\"R\":-0.20}\n", -1, 1'b1, 8'd1, 16'(-50), 16'(-20));
    send("{\"T\":0,\"L\":00.00,\"R\":00.00}\n", -1, 1'b1, 8'd0, 16'd0, 16'd0);
    send("{\"T\":1,\"L\":-0.25,\"R\":-0.25}\n", -1, 1'b1, 8'd1, 16'(-25), 16'(-25));
    send("{\"T\":1,\"L\":-0.5{\"T\":1,\"L\":-0.10,\"R\":-0.05}\n", 15, 1'b1,
         8'd1, 16'(-10), 16'(-5));
    send("{\"T\":255,\"L\":99.99,\"R\":-99.99}\n", -1, 1'b1, 8'd255, 16'd9999, 16'(-9999));
    send("{\"T\":7,\"L\":-0.00,\"R\":5.01}\n", -1, 1'b1, 8'd7, 16'd0, 16'd501);
    send("ab}\n\"T:", -1, 1'b0, 8'd0, 16'd0, 16'd0);

    for (int k = 0; k < NBAD; k++) send(bad_s[k], bad_i[k], 1'b0, 8'd0, 16'd0, 16'd0);

    for (int k = 0; k < 40; k++) begin
      gen_frame(s, t, l, r);
      send(s, -1, 1'b1, t, l, r);
    end

    for (int k = 0; k < 20; k++) begin
      gen_frame(s, t, l, r);
      idx = int'($urandom_range(1, s.len() - 1));
      s.putc(idx, 8'h58);
      send(s, idx, 1'b0, t, l, r);
    end

    for (int k = 0; k < 10; k++) begin
      gen_frame(s, t, l, r);
      idx = int'($urandom_range(1, s.len() - 1));
      gen_frame(s2, t, l, r);
      send({s.substr(0, idx - 1), s2}, idx, 1'b1, t, l, r);
    end

`ifndef JSON_PARSER_TIMEOUT_EN
    begin
      bit saw_pulse;
      saw_pulse = 1'b0;
      send("{\"T\":9,\"L\":1.", -1, 1'b0, 8'd0, 16'd0, 16'd0);
      repeat (300) begin
        @(posedge clk); #1;
        if (frame_error || frame_valid) saw_pulse = 1'b1;
      end
      check("stall pulse", 32'(saw_pulse), 32'(0));
      send("25,\"R\":-3.07}\n", -1, 1'b1, 8'd9, 16'd125, 16'(-307));
    end
`endif

    send("{\"T\":7,\"L\":", -1, 1'b0, 8'd0, 16'd0, 16'd0);
    rst_n = 1'b0;
    #2;
    ref_t = '0;
    ref_l = '0;
    ref_r = '0;
    check("midreset frame_valid", 32'(frame_valid), 32'(0));
    check("midreset frame_error", 32'(frame_error), 32'(0));
    check_fields("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(",\"R\":1.00}\n", -1, 1'b0, 8'd0, 16'd0, 16'd0);
    send("{\"T\":42,\"L\":12.34,\"R\":-5.67}\n", -1, 1'b1, 8'd42, 16'd1234, 16'(-567));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
